// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the bounded random-value sampler.
// range_mask() gives the smallest all-ones mask covering limit-1.
package lfsr_pkg;

  localparam int OUT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smear the top set bit of limit-1 downward; limit==1 yields an empty mask.
  function automatic logic [31:0] range_mask(input logic [31:0] limit);
    logic [31:0] m;
    m = limit - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Small synchronous FIFO holding accepted samples ahead of the output handshake.
// The head reads as zero while empty so the output never carries stale or X data.
module rng_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit separates the full and empty cases when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Turns raw LFSR words into `count` values uniform in [0, limit) by mask-and-reject,
// buffering them in a FIFO behind a valid/ready output.
module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] limit,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] reject_cnt
);

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] limit_q;
  logic [OUT_W-1:0] mask_q;
  logic [OUT_W-1:0] mask_d;
  logic [OUT_W-1:0] cand;
  logic [CNT_W-1:0] remaining;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load_ok;
  logic             load_bad;
  logic             accept;
  logic             take;
  logic             in_word_unused;

  // Only the low OUT_W bits of each word feed the sampler.
  assign in_word_unused = ^in_word[31:OUT_W];

  assign mask_d   = OUT_W'(range_mask(32'(limit)));
  assign cand     = in_word[OUT_W-1:0] & mask_q;
  assign load_ok  = (state == IDLE) && load && (limit != '0) && (count != '0);
  assign load_bad = (state == IDLE) && load && ((limit == '0) || (count == '0));
  assign accept   = in_valid && in_ready;
  assign take     = accept && (cand < limit_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_ok) state_next = RUN;
      end
      RUN: begin
        in_ready = !fifo_full && (remaining != '0);
        if (take && (remaining == CNT_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        // Last value has been popped: report completion while leaving DRAIN.
        if (fifo_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q    <= '0;
      mask_q     <= '0;
      remaining  <= '0;
      reject_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      if (load_ok) begin
        limit_q    <= limit;
        mask_q     <= mask_d;
        remaining  <= count;
        reject_cnt <= '0;
        cfg_err    <= 1'b0;
      end else if (load_bad) begin
        cfg_err <= 1'b1;
      end
      if (take) begin
        remaining <= remaining - CNT_W'(1);
      end else if (accept && (reject_cnt != '1)) begin
        reject_cnt <= reject_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = !fifo_empty;

  rng_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (take),
    .pop   (out_ready),
    .din   (cand),
    .dout  (out_value),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Randomized scoreboard bench: a reference model predicts handshakes and sampled values,
// a separate monitor pops expected values whenever the DUT delivers an output.
module tb_lfsr_range_sampler;

  localparam int OUT_W = 8;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int REJ_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [OUT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic [31:0]      in_word;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_value;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: pending-value queue plus a few counters derived from the rules.
  int exp_q[$];
  int m_occ = 0, m_rem = 0, m_limit = 0, m_rej = 0;
  bit m_busy = 0, m_drain = 0, m_cfg = 0;
  int dut_done_cnt = 0, dut_pops = 0;
  bit pre_busy, exp_ready, exp_done, do_pop, do_finish;
  int cand, exp_val;

  always #5 clk = ~clk;

  lfsr_range_sampler #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .limit      (limit),
    .count      (count),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .reject_cnt (reject_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Smallest power of two not below limit, minus one.
  function automatic int model_mask(input int lim);
    int p = 1;
    while (p < lim) p = p * 2;
    return p - 1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_occ = 0; m_rem = 0; m_limit = 0; m_rej = 0;
      m_busy = 0; m_drain = 0; m_cfg = 0;
    end else begin
      pre_busy  = m_busy;
      exp_ready = m_busy && !m_drain && (m_occ < DEPTH) && (m_rem != 0);
      exp_done  = m_busy && m_drain && (m_occ == 0);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("out_valid", out_valid, m_occ != 0);
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, exp_done);
      checkOutput("cfg_err", cfg_err, m_cfg);
      checkOutput("reject_cnt", reject_cnt, m_rej);
      do_pop    = out_ready && (m_occ != 0);
      do_finish = exp_done;
      if (in_valid && exp_ready) begin
        cand = int'(in_word[OUT_W-1:0]) & model_mask(m_limit);
        if (cand < m_limit) begin
          exp_q.push_back(cand);
          m_occ++;
          m_rem--;
          if (m_rem == 0) m_drain = 1;
        end else if (m_rej < REJ_MAX) begin
          m_rej++;
        end
      end
      if (do_pop) m_occ--;
      if (do_finish) begin
        m_busy  = 0;
        m_drain = 0;
      end
      if (load && !pre_busy) begin
        if (limit == 0 || count == 0) begin
          m_cfg = 1;
        end else begin
          m_cfg   = 0;
          m_limit = int'(limit);
          m_rem   = int'(count);
          m_rej   = 0;
          m_busy  = 1;
          m_drain = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) dut_done_cnt++;
      if (out_valid && out_ready) begin
        dut_pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d expected none", out_value);
        end else begin
          exp_val = exp_q.pop_front();
          checkOutput("out_value", out_value, exp_val);
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic applyStimulus(input int l, input int c);
    load  = 1'b1;
    limit = OUT_W'(l);
    count = CNT_W'(c);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] w);
    bit got = 0;
    in_word  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("feed_handshake", got, 1);
  endtask

  task automatic feed_low(input logic [7:0] lo);
    logic [31:0] r;
    r = $urandom();
    feed_word({r[31:8], lo});
  endtask

  task automatic run_random(input int vpct, input int rpct, input int budget, input bit stop_idle);
    bit idle = 0;
    for (int i = 0; i < budget && !(stop_idle && idle); i++) begin
      in_valid  = ($urandom % 100) < vpct;
      in_word   = $urandom();
      out_ready = ($urandom % 100) < rpct;
      @(negedge clk);
      idle = !busy;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (stop_idle) checkOutput("run_to_idle", idle, 1);
  endtask

  initial begin
    int done_before, pops_before, accepts;
    rst = 1'b1; load = 1'b0; limit = '0; count = '0;
    in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_value", out_value, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_reject_cnt", reject_cnt, 0);
    @(posedge clk); #1;

    $display("[TB] basic run limit=10 count=3");
    out_ready = 1'b1;
    done_before = dut_done_cnt;
    applyStimulus(10, 3);
    feed_low(8'h03); feed_low(8'h0C); feed_low(8'hF5); feed_low(8'h29);
    @(negedge clk);
    checkOutput("basic_reject_cnt", reject_cnt, 1);
    @(posedge clk); #1;
    run_random(0, 100, 50, 1);
    checkOutput("basic_done_pulses", dut_done_cnt - done_before, 1);

    $display("[TB] limit=1 count=4");
    applyStimulus(1, 4);
    run_random(80, 100, 100, 1);

    $display("[TB] backpressure limit=255 count=8");
    out_ready = 1'b0;
    applyStimulus(255, 8);
    accepts = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_word = $urandom() & 32'hFFFF_FF7F;
      @(negedge clk);
      if (in_ready) accepts++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", accepts, DEPTH);
    @(negedge clk);
    checkOutput("bp_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    run_random(100, 100, 200, 1);

    $display("[TB] bad config then recovery");
    applyStimulus(0, 3);
    @(negedge clk);
    checkOutput("bad_cfg_err", cfg_err, 1);
    checkOutput("bad_busy", busy, 0);
    @(posedge clk); #1;
    applyStimulus(5, 1);
    @(negedge clk);
    checkOutput("good_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    run_random(100, 100, 100, 1);

    $display("[TB] reset during run");
    out_ready = 1'b0;
    done_before = dut_done_cnt;
    applyStimulus(200, 10);
    feed_low(8'($urandom % 128));
    feed_low(8'($urandom % 128));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_reject_cnt", reject_cnt, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done_pulses", dut_done_cnt - done_before, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    $display("[TB] load while busy ignored");
    pops_before = dut_pops;
    applyStimulus(3, 2);
    applyStimulus(100, 15);
    run_random(100, 100, 100, 1);
    checkOutput("ignored_load_pops", dut_pops - pops_before, 2);

    $display("[TB] reject counter saturation");
    applyStimulus(129, 1);
    for (int i = 0; i < 20; i++) feed_low(8'(129 + $urandom % 127));
    @(negedge clk);
    checkOutput("sat_reject_cnt", reject_cnt, REJ_MAX);
    @(posedge clk); #1;
    feed_low(8'h05);
    run_random(0, 100, 50, 1);

    $display("[TB] randomized runs");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1 + $urandom % 255, 1 + $urandom % 15);
      run_random(70, 60, 600, 1);
    end
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
